// File: rtl/pipe3_pkg.sv
// Shared fetch-stage definitions: datapath width, reset PC, NOP encoding and the {pc, instr} bundle.
// Pure declarations; no logic, no latency, no flow control.
package pipe3_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_bundle_t;

endpackage

// File: rtl/pipe3_skid_buffer.sv
// One-entry output register plus one skid entry; in->out latency 1 cycle, full rate.
// Backpressure: in_ready drops while the skid holds data; flush empties both entries.
module pipe3_skid_buffer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         out_take;

    assign out_take = !out_valid || out_ready;
    assign in_ready = !skid_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_take) begin
            // Older skid data always drains ahead of anything arriving now.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= in_valid;
                if (in_valid) skid_data <= in_data;
            end else begin
                out_valid <= in_valid;
                if (in_valid) out_data <= in_data;
            end
        end else if (in_valid) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe3_fetch_stage.sv
// PC + sync-read imem fetch; issue to out_valid 2 cycles, 1 instr/cycle steady; redirect flushes.
// Stops issuing when a returning read could not be buffered. Optional FETCH_PERF_CNT_EN adds perf counters.
module pipe3_fetch_stage #(
    parameter int              XLEN     = pipe3_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(pipe3_pkg::RESET_PC),
    parameter int              IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_instr,
    output logic [XLEN-1:0]    out_pc
);

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inflight_pc;
    logic              inflight;
    logic              buf_in_ready;
    logic              issue;
    logic [2*XLEN-1:0] buf_out;

    // A read is only issued when its return is guaranteed a free slot.
    assign issue     = rst && !redirect_valid && buf_in_ready
                       && !(inflight && out_valid && !out_ready);
    assign imem_en   = issue;
    assign imem_addr = pc[IMEM_AW+1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & ~XLEN'(3);
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + XLEN'(4);
            end
        end
    end

    pipe3_skid_buffer #(.W(2*XLEN)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .in_valid  (inflight),
        .in_ready  (buf_in_ready),
        .in_data   ({inflight_pc, imem_rdata}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign {out_pc, out_instr} = buf_out;

`ifdef FETCH_PERF_CNT_EN
    // Redirects deliberately leave the counters untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (out_valid && out_ready)  perf_fetched <= perf_fetched + 32'd1;
            if (out_valid && !out_ready) perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe3_fetch_stage.sv
// Directed per-cycle vector table for pipe3_fetch_stage plus reset/perf sequences.
module tb_pipe3_fetch_stage;
    import pipe3_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    pipe3_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    // Instruction memory: word n holds 32'h1000_0000 + n, one-cycle read.
    always_ff @(posedge clk)
        if (imem_en) imem_rdata <= 32'h1000_0000 + {24'h0, imem_addr};

    typedef struct {
        logic          rdy;
        logic          rv;
        logic [31:0]   rpc;
        logic          en;
        logic [7:0]    addr;
        logic          ov;
        fetch_bundle_t exp;
    } vec_t;

    vec_t vt[23];

    function automatic vec_t mkv(input logic rdy, input logic rv, input logic [31:0] rpc,
                                 input logic en, input logic [7:0] addr,
                                 input logic ov, input logic [31:0] pc);
        vec_t v;
        v.rdy       = rdy;
        v.rv        = rv;
        v.rpc       = rpc;
        v.en        = en;
        v.addr      = addr;
        v.ov        = ov;
        v.exp.pc    = pc;
        v.exp.instr = 32'h1000_0000 + (pc >> 2);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        // Cycle 0 is the first cycle after reset release.
        //           rdy rv  rpc           en addr ov pc
        vt[0]  = mkv(1, 0, 32'h0,         1, 0,   0, 32'h0);
        vt[1]  = mkv(1, 0, 32'h0,         1, 1,   0, 32'h0);
        vt[2]  = mkv(1, 0, 32'h0,         1, 2,   1, 32'h0);
        vt[3]  = mkv(1, 0, 32'h0,         1, 3,   1, 32'h4);
        vt[4]  = mkv(0, 0, 32'h0,         0, 4,   1, 32'h8);
        vt[5]  = mkv(0, 0, 32'h0,         0, 4,   1, 32'h8);
        vt[6]  = mkv(0, 0, 32'h0,         0, 4,   1, 32'h8);
        vt[7]  = mkv(1, 0, 32'h0,         0, 4,   1, 32'h8);
        vt[8]  = mkv(1, 0, 32'h0,         1, 4,   1, 32'hC);
        vt[9]  = mkv(1, 0, 32'h0,         1, 5,   0, 32'h0);
        vt[10] = mkv(1, 0, 32'h0,         1, 6,   1, 32'h10);
        vt[11] = mkv(0, 0, 32'h0,         0, 7,   1, 32'h14);
        vt[12] = mkv(0, 1, 32'h0000_0043, 0, 7,   1, 32'h14);
        vt[13] = mkv(1, 0, 32'h0,         1, 16,  0, 32'h0);
        vt[14] = mkv(1, 0, 32'h0,         1, 17,  0, 32'h0);
        vt[15] = mkv(1, 0, 32'h0,         1, 18,  1, 32'h40);
        vt[16] = mkv(1, 1, 32'h0000_0200, 0, 19,  1, 32'h44);
        vt[17] = mkv(1, 1, 32'h0000_0080, 0, 128, 0, 32'h0);
        vt[18] = mkv(1, 0, 32'h0,         1, 32,  0, 32'h0);
        vt[19] = mkv(1, 0, 32'h0,         1, 33,  0, 32'h0);
        vt[20] = mkv(1, 0, 32'h0,         1, 34,  1, 32'h80);
        vt[21] = mkv(1, 0, 32'h0,         1, 35,  1, 32'h84);
        vt[22] = mkv(0, 0, 32'h0,         0, 36,  1, 32'h88);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset imem_en",   {31'h0, imem_en},   32'h0);
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset out_pc",    out_pc,             32'h0);
        chk("reset out_instr", out_instr,          32'h0);
        chk("reset imem_addr", {24'h0, imem_addr}, 32'h0);

        for (int i = 0; i < 23; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) rst = 1'b1;
            out_ready      = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            @(negedge clk);
            chk($sformatf("c%0d imem_en", i),   {31'h0, imem_en},   {31'h0, vt[i].en});
            chk($sformatf("c%0d imem_addr", i), {24'h0, imem_addr}, {24'h0, vt[i].addr});
            chk($sformatf("c%0d out_valid", i), {31'h0, out_valid}, {31'h0, vt[i].ov});
            if (vt[i].ov) begin
                chk($sformatf("c%0d out_pc", i),    out_pc,    vt[i].exp.pc);
                chk($sformatf("c%0d out_instr", i), out_instr, vt[i].exp.instr);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched after table", perf_fetched, 32'd9);
        chk("perf_stall after table",   perf_stall,   32'd5);
`endif

        // Skid is full here; async reset must clear everything without a clock edge.
        @(posedge clk);
        #1;
        rst            = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        #1;
        chk("midrst out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst imem_en",   {31'h0, imem_en},   32'h0);
        chk("midrst out_pc",    out_pc,             32'h0);
        chk("midrst out_instr", out_instr,          32'h0);
        repeat (2) @(posedge clk);

        // Restart from RESET_PC: 10 accepts (cycles 2..11), then 4 stall cycles.
        for (int c = 0; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rst = 1'b1;
            out_ready = (c < 12);
            @(negedge clk);
            if (c == 0) begin
                chk("restart imem_en",   {31'h0, imem_en},   32'h1);
                chk("restart imem_addr", {24'h0, imem_addr}, 32'h0);
            end
            if (c < 2) begin
                chk($sformatf("restart c%0d out_valid", c), {31'h0, out_valid}, 32'h0);
            end else begin
                chk($sformatf("restart c%0d out_valid", c), {31'h0, out_valid}, 32'h1);
                chk($sformatf("restart c%0d out_pc", c), out_pc,
                    (c <= 11) ? 32'((c - 2) * 4) : 32'd40);
                chk($sformatf("restart c%0d out_instr", c), out_instr,
                    (c <= 11) ? 32'h1000_0000 + 32'(c - 2) : 32'h1000_000A);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'd10);
        chk("perf_stall",   perf_stall,   32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
